// File: rtl/tron_pkg.sv
// Shared types and constants for the tron display path.
// Holds the direction encoding, colour enum values and screen size.
package tron_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam logic [3:0] COL_BG         = 4'd0;
  localparam logic [3:0] COL_RED_TRAIL  = 4'd4;
  localparam logic [3:0] COL_BLUE_TRAIL = 4'd6;
  localparam logic [3:0] COL_BLOCK      = 4'd7;
  localparam logic [3:0] COL_TRANSP     = 4'd15;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

endpackage

// File: rtl/tron_head_probe.sv
// Head probe for one bike: places a point ahead of and beside the bike origin
// and flags when the current scan position lands exactly on it.
module tron_head_probe
  import tron_pkg::*;
#(
  parameter int HEAD_FWD  = 16,
  parameter int HEAD_SIDE = 3,
  parameter int SCR_W     = 640,
  parameter int SCR_H     = 480
) (
  input  logic       pix_valid,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] bike_x,
  input  logic [9:0] bike_y,
  input  dir_e       bike_dir,
  output logic       probe_match
);

  logic [9:0] w_fwd;
  logic [9:0] w_side;
  logic [9:0] w_px;
  logic [9:0] w_py;

  assign w_fwd  = 10'(HEAD_FWD);
  assign w_side = 10'(HEAD_SIDE);

  // 10-bit wrap is intentional; a wrapped point lands off-screen and never matches.
  always_comb begin
    w_px = bike_x + w_side;
    w_py = bike_y + w_fwd;
    unique case (bike_dir)
      DIR_DOWN:  begin w_px = bike_x + w_side; w_py = bike_y + w_fwd;  end
      DIR_UP:    begin w_px = bike_x + w_side; w_py = bike_y - w_fwd;  end
      DIR_RIGHT: begin w_px = bike_x + w_fwd;  w_py = bike_y + w_side; end
      DIR_LEFT:  begin w_px = bike_x - w_fwd;  w_py = bike_y + w_side; end
      default:   begin w_px = bike_x + w_side; w_py = bike_y + w_fwd;  end
    endcase
  end

  assign probe_match = pix_valid
                    && (draw_x == w_px) && (draw_y == w_py)
                    && (int'(w_px) < SCR_W) && (int'(w_py) < SCR_H);

endmodule

// File: rtl/tron_pixel_compositor.sv
// Two-stage pixel compositor: trail frame buffer + sprite overlay + blocked
// override, with per-frame head collision flags. Optional macro COMPOSITOR_HIT_CNT_EN adds hit_cnt.
module tron_pixel_compositor
  import tron_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int PIX_BITS     = 4,
  parameter int PIX_PER_WORD = 2,
  parameter int LANE_W       = 8,
  parameter int H_RES        = tron_pkg::H_RES,
  parameter int ADDR_W       = 19,
  parameter int HEAD_FWD     = 16,
  parameter int HEAD_SIDE    = 3,
  parameter int BG_COLOR     = int'(COL_BG),
  parameter int TRANSP       = int'(COL_TRANSP),
  parameter int BLOCK_COLOR  = int'(COL_BLOCK)
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             frame_clk,
  input  logic                             pix_valid,
  input  logic [9:0]                       DrawX,
  input  logic [9:0]                       DrawY,
  input  logic [NUM_PLAYERS*PIX_BITS-1:0]  sprite_px,
  input  logic [NUM_PLAYERS-1:0]           sprite_hit,
  input  logic [NUM_PLAYERS*10-1:0]        bike_x,
  input  logic [NUM_PLAYERS*10-1:0]        bike_y,
  input  logic [NUM_PLAYERS*2-1:0]         bike_dir,
  input  logic [NUM_PLAYERS-1:0]           is_blocked,
  output logic [ADDR_W-1:0]                fb_rd_addr,
  input  logic [PIX_PER_WORD*LANE_W-1:0]   fb_rd_data,
  output logic [PIX_BITS-1:0]              color_enum,
  output logic                             color_valid,
  output logic [NUM_PLAYERS-1:0]           hit,
  output logic                             hit_valid
`ifdef COMPOSITOR_HIT_CNT_EN
  ,
  output logic [NUM_PLAYERS*8-1:0]         hit_cnt
`endif
);

  localparam int WORDS_PER_LINE = H_RES / PIX_PER_WORD;
  localparam int LANE_SEL_W     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  logic [31:0]                      w_addr_full;
  logic [LANE_SEL_W-1:0]            w_lane;
  logic [NUM_PLAYERS-1:0]           w_probe_match;

  logic                             r1_valid;
  logic [LANE_SEL_W-1:0]            r1_lane;
  logic [NUM_PLAYERS*PIX_BITS-1:0]  r1_spx;
  logic [NUM_PLAYERS-1:0]           r1_shit;
  logic [NUM_PLAYERS-1:0]           r1_probe;

  logic [PIX_BITS-1:0]              w_trail;
  logic [PIX_BITS-1:0]              w_sprite_col;
  logic                             w_sprite_any;
  logic [PIX_BITS-1:0]              w_color;
  logic [NUM_PLAYERS-1:0]           w_probe_hit;
  logic [NUM_PLAYERS-1:0]           w_hit_next;
  logic                             w_frame_edge;

  logic [PIX_BITS-1:0]              r_color;
  logic                             r_color_valid;
  logic [NUM_PLAYERS-1:0]           r_acc;
  logic [NUM_PLAYERS-1:0]           r_hit;
  logic                             r_hit_valid;
  logic                             r_fclk_d;

  // S0: address is combinational so the RAM's 1-cycle latency lines up with S1.
  assign w_addr_full = 32'(DrawX) / 32'(PIX_PER_WORD) + 32'(DrawY) * 32'(WORDS_PER_LINE);
  assign fb_rd_addr  = Reset ? '0 : w_addr_full[ADDR_W-1:0];
  assign w_lane      = LANE_SEL_W'(32'(DrawX) % 32'(PIX_PER_WORD));

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_probe
    tron_head_probe #(
      .HEAD_FWD  (HEAD_FWD),
      .HEAD_SIDE (HEAD_SIDE),
      .SCR_W     (H_RES),
      .SCR_H     (V_RES)
    ) u_probe (
      .pix_valid   (pix_valid),
      .draw_x      (DrawX),
      .draw_y      (DrawY),
      .bike_x      (bike_x[10*g +: 10]),
      .bike_y      (bike_y[10*g +: 10]),
      .bike_dir    (dir_e'(bike_dir[2*g +: 2])),
      .probe_match (w_probe_match[g])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r1_valid <= 1'b0;
      r1_lane  <= '0;
      r1_spx   <= '0;
      r1_shit  <= '0;
      r1_probe <= '0;
    end else begin
      r1_valid <= pix_valid;
      r1_lane  <= w_lane;
      r1_spx   <= sprite_px;
      r1_shit  <= sprite_hit;
      r1_probe <= w_probe_match;
    end
  end

  // S1: fb_rd_data is valid now for the address issued in S0.
  assign w_trail = fb_rd_data[int'(r1_lane)*LANE_W +: PIX_BITS];

  // Walk high to low so the lowest visible player index wins.
  always_comb begin
    w_sprite_any = 1'b0;
    w_sprite_col = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (r1_shit[i] && (r1_spx[i*PIX_BITS +: PIX_BITS] != PIX_BITS'(TRANSP))) begin
        w_sprite_any = 1'b1;
        w_sprite_col = r1_spx[i*PIX_BITS +: PIX_BITS];
      end
    end
    if (|is_blocked)
      w_color = PIX_BITS'(BLOCK_COLOR);
    else if (w_sprite_any)
      w_color = w_sprite_col;
    else
      w_color = w_trail;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_color       <= '0;
      r_color_valid <= 1'b0;
    end else begin
      r_color_valid <= r1_valid;
      if (r1_valid)
        r_color <= w_color;
    end
  end

  assign w_probe_hit  = (r1_probe & {NUM_PLAYERS{r1_valid}})
                      & {NUM_PLAYERS{w_trail != PIX_BITS'(BG_COLOR)}};
  assign w_hit_next   = r_acc | w_probe_hit;
  assign w_frame_edge = frame_clk & ~r_fclk_d;

  // A probe hit landing on the frame-edge cycle is folded into this frame's result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fclk_d    <= 1'b0;
      r_acc       <= '0;
      r_hit       <= '0;
      r_hit_valid <= 1'b0;
    end else begin
      r_fclk_d <= frame_clk;
      if (w_frame_edge) begin
        r_hit       <= w_hit_next;
        r_acc       <= '0;
        r_hit_valid <= 1'b1;
      end else begin
        r_acc       <= w_hit_next;
        r_hit_valid <= 1'b0;
      end
    end
  end

`ifdef COMPOSITOR_HIT_CNT_EN
  logic [NUM_PLAYERS*8-1:0] r_hit_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hit_cnt <= '0;
    end else if (w_frame_edge) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (w_hit_next[i] && (r_hit_cnt[i*8 +: 8] != 8'hFF))
          r_hit_cnt[i*8 +: 8] <= r_hit_cnt[i*8 +: 8] + 8'd1;
      end
    end
  end

  assign hit_cnt = r_hit_cnt;
`endif

  assign color_enum  = r_color;
  assign color_valid = r_color_valid;
  assign hit         = r_hit;
  assign hit_valid   = r_hit_valid;

endmodule

// File: tb/tb_tron_pixel_compositor.sv
// Directed bench for tron_pixel_compositor: colour scoreboard, frame-buffer model,
// collision frames and reset; covers hit_cnt when COMPOSITOR_HIT_CNT_EN is defined.
module tb_tron_pixel_compositor;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [7:0]  sprite_px;
  logic [1:0]  sprite_hit;
  logic [19:0] bike_x;
  logic [19:0] bike_y;
  logic [3:0]  bike_dir;
  logic [1:0]  is_blocked;
  logic [18:0] fb_rd_addr;
  logic [15:0] fb_rd_data;
  logic [3:0]  color_enum;
  logic        color_valid;
  logic [1:0]  hit;
  logic        hit_valid;
`ifdef COMPOSITOR_HIT_CNT_EN
  logic [15:0] hit_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] fb_mem [int];
  int          exp_q [$];
  logic        drv_v = 1'b0;
  logic        m_s1  = 1'b0;
  logic        m_s2  = 1'b0;
  int          last_color = 0;

  tron_pixel_compositor dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_px   (sprite_px),
    .sprite_hit  (sprite_hit),
    .bike_x      (bike_x),
    .bike_y      (bike_y),
    .bike_dir    (bike_dir),
    .is_blocked  (is_blocked),
    .fb_rd_addr  (fb_rd_addr),
    .fb_rd_data  (fb_rd_data),
    .color_enum  (color_enum),
    .color_valid (color_valid),
    .hit         (hit),
    .hit_valid   (hit_valid)
`ifdef COMPOSITOR_HIT_CNT_EN
    ,
    .hit_cnt     (hit_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] mem_rd(int a);
    return fb_mem.exists(a) ? fb_mem[a] : 16'h0000;
  endfunction

  // 1-cycle-latency RAM model
  always @(posedge Clk) fb_rd_data <= mem_rd(int'(fb_rd_addr));

  function automatic int exp_addr(int x, int y);
    return (x / 2 + y * 320) & 32'h7FFFF;
  endfunction

  function automatic int model(int x, int y, logic [7:0] spx, logic [1:0] shit, logic [1:0] blk);
    logic [15:0] w;
    int          lane;
    w    = mem_rd(exp_addr(x, y));
    lane = x % 2;
    if (blk != 2'b00) return 7;
    for (int i = 0; i < 2; i++)
      if (shit[i] && (spx[i*4 +: 4] != 4'hF)) return int'(spx[i*4 +: 4]);
    return int'(w[lane*8 +: 4]);
  endfunction

  task automatic chk(string tag, int obs, int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    int e;
    @(posedge Clk);
    if (Reset) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      exp_q.delete();
      last_color = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = drv_v;
    end
    #1;
    chk("color_valid", int'(color_valid), int'(m_s2));
    if (m_s2) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("color_enum", int'(color_enum), e);
      last_color = e;
    end else begin
      chk("color_hold", int'(color_enum), last_color);
    end
  endtask

  task automatic drive(int x, int y, logic [7:0] spx, logic [1:0] shit);
    DrawX      = 10'(x);
    DrawY      = 10'(y);
    sprite_px  = spx;
    sprite_hit = shit;
    pix_valid  = 1'b1;
    drv_v      = 1'b1;
    exp_q.push_back(model(x, y, spx, shit, is_blocked));
    #1;
    chk("fb_rd_addr", int'(fb_rd_addr), exp_addr(x, y));
    tick();
  endtask

  task automatic idle(int n);
    pix_valid = 1'b0;
    drv_v     = 1'b0;
    repeat (n) tick();
  endtask

  task automatic frame_pulse(logic [1:0] exp_hit);
    frame_clk = 1'b1;
    tick();
    chk("hit", int'(hit), int'(exp_hit));
    chk("hit_valid", int'(hit_valid), 1);
    tick();
    chk("hit_valid_pulse", int'(hit_valid), 0);
    chk("hit_hold", int'(hit), int'(exp_hit));
    frame_clk = 1'b0;
    tick();
  endtask

  initial begin
    Reset      = 1'b1;
    frame_clk  = 1'b0;
    pix_valid  = 1'b0;
    DrawX      = '0;
    DrawY      = '0;
    sprite_px  = 8'hFF;
    sprite_hit = 2'b00;
    bike_x     = {10'd5, 10'd100};
    bike_y     = {10'd50, 10'd200};
    bike_dir   = {2'b11, 2'b00};
    is_blocked = 2'b00;

    fb_mem[2]     = 16'h0302;
    fb_mem[69171] = 16'h0600;  // (103,216) lane 1 = 6
    fb_mem[17466] = 16'h0400;  // (1013,53) lane 1 = 4
    fb_mem[16960] = 16'h0400;  // (1,53) lane 1 = 4

    tick();
    tick();
    chk("rst_hit", int'(hit), 0);
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_fb_rd_addr", int'(fb_rd_addr), 0);
    Reset = 1'b0;
    idle(2);

    // trail lanes and sprite priority, back to back
    drive(5, 0, 8'hFF, 2'b00);
    drive(4, 0, 8'hFF, 2'b00);
    drive(5, 0, 8'h59, 2'b11);
    drive(5, 0, 8'h5F, 2'b11);
    drive(5, 0, 8'hFF, 2'b11);
    drive(4, 0, 8'h59, 2'b10);
    idle(3);

    // blocked override, then release
    is_blocked = 2'b01;
    drive(5, 0, 8'h59, 2'b11);
    drive(4, 0, 8'hFF, 2'b00);
    idle(2);
    is_blocked = 2'b10;
    drive(5, 0, 8'hFF, 2'b00);
    idle(2);
    is_blocked = 2'b00;
    drive(5, 0, 8'h59, 2'b11);
    idle(2);

    // frame 1: bike0 head on trail; bike1 probe wraps off-screen
    drive(103, 216, 8'hFF, 2'b00);
    drive(1013, 53, 8'hFF, 2'b00);
    drive(1, 53, 8'hFF, 2'b00);
    idle(2);
    frame_pulse(2'b01);

    // frame 2: trail gone under bike0 head
    fb_mem.delete(69171);
    drive(103, 216, 8'hFF, 2'b00);
    drive(1013, 53, 8'hFF, 2'b00);
    idle(2);
    frame_pulse(2'b00);

    // frame 3: both heads on trail (bike1 heading right); probe hit on the edge cycle
    fb_mem[69171] = 16'h0600;
    bike_x   = {10'd300, 10'd100};
    bike_y   = {10'd100, 10'd200};
    bike_dir = {2'b10, 2'b00};
    fb_mem[33118] = 16'h0004;  // (316,103) lane 0 = 4
    drive(316, 103, 8'hFF, 2'b00);
    idle(2);
    drive(103, 216, 8'hFF, 2'b00);
    pix_valid = 1'b0;
    drv_v     = 1'b0;
    frame_pulse(2'b11);

    // reset mid-scan drops in-flight pixels and clears hit
    drive(5, 0, 8'h59, 2'b11);
    drive(4, 0, 8'hFF, 2'b00);
    Reset = 1'b1;
    tick();
    chk("midrst_hit", int'(hit), 0);
    chk("midrst_fb_rd_addr", int'(fb_rd_addr), 0);
    Reset = 1'b0;
    idle(2);
    drive(4, 0, 8'hFF, 2'b00);
    idle(2);
    frame_pulse(2'b00);

`ifdef COMPOSITOR_HIT_CNT_EN
    for (int f = 0; f < 300; f++) begin
      drive(103, 216, 8'hFF, 2'b00);
      idle(2);
      frame_pulse(2'b01);
    end
    chk("hit_cnt0_sat", int'(hit_cnt[7:0]), 255);
    chk("hit_cnt1", int'(hit_cnt[15:8]), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tron_pixel_compositor.md
Name: tron_pixel_compositor

Overview:
Pipelined per-pixel compositor between the VGA scan counters, the frame buffer RAM and the colour-mapper. For each scan position it reads the packed trail frame buffer and overlays NUM_PLAYERS bike sprites. It applies the global "blocked" override and emits a 2-cycle-latency colour enum. It also probes each bike's head pixel against the trail layer and reports per-player collision flags once per frame.

Parameters:
NUM_PLAYERS, 2, number of bikes/sprite channels (1..4)
PIX_BITS, 4, colour enum width
PIX_PER_WORD, 2, pixels packed per frame-buffer word; power of 2
LANE_W, 8, bit stride per pixel lane in a word; colour sits in lane[PIX_BITS-1:0]
H_RES, 640, visible width in pixels
ADDR_W, 19, frame-buffer read address width
HEAD_FWD, 16, head probe offset along the direction of travel
HEAD_SIDE, 3, head probe offset across the direction of travel
BG_COLOR, 0, trail-layer background enum
TRANSP, 15, sprite transparent enum
BLOCK_COLOR, 7, enum forced while any player is blocked

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_clk  in  1  frame strobe (~60 Hz); a rising edge marks end of frame
pix_valid  in  1  DrawX/DrawY are valid this cycle
DrawX  in  10  scan X
DrawY  in  10  scan Y
sprite_px  in  NUM_PLAYERS*PIX_BITS  per-player sprite pixel at (DrawX,DrawY), same cycle
sprite_hit  in  NUM_PLAYERS  scan position lies inside player i's sprite box
bike_x  in  NUM_PLAYERS*10  bike origin X
bike_y  in  NUM_PLAYERS*10  bike origin Y
bike_dir  in  NUM_PLAYERS*2  00 down, 01 up, 10 right, 11 left
is_blocked  in  NUM_PLAYERS  per-player blocked flag
fb_rd_addr  out  ADDR_W  frame-buffer read address (RAM has 1-cycle read latency)
fb_rd_data  in  PIX_PER_WORD*LANE_W  RAM data, valid 1 cycle after the address
color_enum  out  PIX_BITS  composited colour
color_valid  out  1  color_enum is valid
hit  out  NUM_PLAYERS  per-player collision result of the last completed frame
hit_valid  out  1  one-cycle pulse when hit updates

Behaviour:
- Reset: color_enum=0, color_valid=0, hit=0, hit_valid=0, fb_rd_addr=0, accumulators=0, frame_clk edge register=0. All pipeline valids are cleared, so in-flight pixels are dropped.
- S0 (combinational): fb_rd_addr = DrawX/PIX_PER_WORD + DrawY*(H_RES/PIX_PER_WORD), truncated to ADDR_W.
- S0 to S1 register: valid, lane = DrawX mod PIX_PER_WORD, sprite_px, sprite_hit, probe-match bits.
- Probe point per player, mod-1024 arithmetic:
  - dir 00: (x+HEAD_SIDE, y+HEAD_FWD)
  - dir 01: (x+HEAD_SIDE, y-HEAD_FWD)
  - dir 10: (x+HEAD_FWD, y+HEAD_SIDE)
  - dir 11: (x-HEAD_FWD, y+HEAD_SIDE)
  - probe_match[i] = pix_valid and DrawX,DrawY equal the probe point.
- S1 to S2 register, which drives the outputs; latency is exactly 2 cycles from pix_valid to color_valid:
  - trail = fb_rd_data[lane*LANE_W +: PIX_BITS].
  - Colour priority: |is_blocked gives BLOCK_COLOR (sampled at S1). Otherwise the lowest index i with sprite_hit[i] and sprite_px[i]!=TRANSP gives sprite_px[i]. Otherwise trail.
  - color_valid = S1 valid. When not valid, color_enum holds its previous value.
- Collision: in S1, if probe_match[i] and trail!=BG_COLOR, set acc[i] (sticky).
- Frame end: on a frame_clk rising edge (registered edge detect), hit<=acc, and acc<=0. If a probe hit occurs in the same cycle, it is ORed into hit and acc still clears. hit_valid pulses for 1 cycle.
- Coordinate wrap: probe coordinates outside 0..H_RES-1 or off-screen simply never match. No clamping.
- Back-to-back pix_valid is supported at full rate. Gaps are allowed, and the pipeline advances every cycle.

Optional Feature:
COMPOSITOR_HIT_CNT_EN:
- Defined: adds output hit_cnt (NUM_PLAYERS*8). Each counter increments at frame end when the player's latched hit=1, saturates at 255, and clears on Reset.
- Undefined: the port and its logic are absent.

Decomposition:
- Package tron_pkg:
  - dir_e enum (DIR_DOWN, DIR_UP, DIR_RIGHT, DIR_LEFT)
  - colour enum constants (BG, BLUE_TRAIL=6, RED_TRAIL=4, BLOCK=7, TRANSP=15)
  - H_RES, V_RES
- Sub-module tron_head_probe: one instance per player via generate. Computes the probe point from bike_x/y/dir plus DrawX/DrawY and outputs probe_match.

Test Plan:
- Scan (DrawX=5, DrawY=0), fb word 0x0_3_0_2 at addr 2 → addr=2 in S0; 2 cycles later color_enum=3, color_valid=1. DrawX=4 → 2.
- Player 0 sprite_hit=1, sprite_px=9; player 1 sprite_hit=1, sprite_px=5 → color 9. Player 0 sprite_px=15 → 5. Both transparent → trail enum.
- is_blocked=01 with sprite visible → color 7; deassert → normal colour resumes after 2 cycles.
- Bike 0 at (100,200) dir 00, trail at (103,216)=6; scan that pixel, then frame_clk edge → hit=01, hit_valid one cycle; next frame with no trail there → hit=00.
- Bike 1 dir 11 at x=5 (probe x wraps to 1013) → never hits. Reset asserted mid-scan → color_valid=0 the next cycle and hit=0.
- COMPOSITOR_HIT_CNT_EN defined: 300 frames with a hit → hit_cnt[0]=255.
